// File: rtl/arbiter_pkg.sv
// Shared definitions for the bus arbiter and its requester-side clients.
package arbiter_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] BURST   = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam int DEF_MAX_BURST = 16;
  localparam int DEF_TIMEOUT   = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_REQ     = REQ,
    ST_BURST   = BURST,
    ST_RELEASE = RELEASE
  } state_t;

endpackage

// File: rtl/arbiter_client_cnt.sv
// Loadable up-counter with an equality compare against a terminal value.
module arbiter_client_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         at_term
);

  // Load has priority over increment so a new command always starts clean.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (load) cnt <= load_val;
    else if (inc)  cnt <= cnt + 1'b1;
  end

  assign at_term = (cnt == term);

endmodule

// File: rtl/arbiter_client.sv
// Requester-side agent: turns a burst command into the arbiter req/gnt
// handshake, counts beats while granted, and enforces a grant-wait timeout
// plus a one-cycle release gap.
//
// state   | meaning
// IDLE    | ready for a command, req low
// REQ     | req high, waiting for gnt, wait counter running
// BURST   | req high, one beat per edge while gnt is high
// RELEASE | req low, done pulse, forces an idle req cycle
module arbiter_client
  import arbiter_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int LEN_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             req,
  input  logic             gnt,
  output logic             bus_en,
  output logic [LEN_W-1:0] beat_cnt,
  output logic             done,
  output logic             timeout_err
);

  // A TIMEOUT of 1 would give a zero-width wait counter; keep at least one bit.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MAX_BURST);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t state, state_nxt;

  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_eff;
  logic [LEN_W-1:0]  beat_term;
  logic [WAIT_W-1:0] wait_cnt;
  logic              accept;
  logic              beat_last;
  logic              wait_last;
  logic              wait_inc;
  logic              req_q;
  logic              req_nxt;
  logic              tmo_q;
  logic              tmo_nxt;

  assign accept    = (state == ST_IDLE) && cmd_valid;
  assign len_eff   = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
  // Terminal compare on len-1 flags the beat in flight as the last one.
  assign beat_term = len_q - 1'b1;
  assign wait_inc  = (state == ST_REQ) && !gnt;

  assign bus_en      = (state == ST_BURST) && gnt;
  assign cmd_ready   = (state == ST_IDLE);
  assign done        = (state == ST_RELEASE);
  assign req         = req_q;
  assign timeout_err = tmo_q;

  arbiter_client_cnt #(.W(LEN_W)) u_beat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val ('0),
    .inc      (bus_en),
    .term     (beat_term),
    .cnt      (beat_cnt),
    .at_term  (beat_last)
  );

  arbiter_client_cnt #(.W(WAIT_W)) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val ('0),
    .inc      (wait_inc),
    .term     (WAIT_LAST),
    .cnt      (wait_cnt),
    .at_term  (wait_last)
  );

  // State, registered req and timeout pulse, and latched burst length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      req_q <= 1'b0;
      tmo_q <= 1'b0;
      len_q <= '0;
    end else begin
      state <= state_nxt;
      req_q <= req_nxt;
      tmo_q <= tmo_nxt;
      if (accept) len_q <= len_eff;
    end
  end

  // Next-state decode; grant wins over timeout on the same edge.
  always_comb begin
    state_nxt = state;
    tmo_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) state_nxt = (len_eff == '0) ? ST_RELEASE : ST_REQ;
      end
      ST_REQ: begin
        if (gnt) begin
          state_nxt = ST_BURST;
        end else if (wait_last) begin
          state_nxt = ST_IDLE;
          tmo_nxt   = 1'b1;
        end
      end
      ST_BURST: begin
        if (gnt && beat_last) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    req_nxt = (state_nxt == ST_REQ) || (state_nxt == ST_BURST);
  end

  logic unused_wait;
  assign unused_wait = ^wait_cnt;

endmodule
